dma_mm2s_burst: RTL and testbench
=================================

DMA_MM2S_BURST -- requirements
Module: dma_mm2s_burst

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64: AXI/AXIS data width in bits, one of 32, 64 or 128.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: AXI address width in bits.
REQ-003 The block SHALL have parameter MAX_BURST_LEN, default 16: maximum beats per AR burst, a power of two from 1 to 256.
REQ-004 The block SHALL have parameter LEN_WIDTH, default 16: width of the transfer-length port.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset.
REQ-006 The block SHALL have port m_axi_aclk, input, 1 bit: clock; all logic samples on its rising edge.
REQ-007 The block SHALL have port m_axi_aresetn, input, 1 bit: synchronous reset, active low.
REQ-008 The block SHALL have ports start_i (input, 1), addr_i (input, ADDR_WIDTH) and len_i (input, LEN_WIDTH): transfer request; len_i is total beats minus 1.
REQ-009 The block SHALL have ports busy_o (output, 1), done_o (output, 1, pulse) and error_o (output, 1, sticky): status.
REQ-010 The block SHALL have AR-channel outputs m_mm2s_axi_araddr[ADDR_WIDTH], arlen[8], arsize[3], arburst[2], arcache[4], arprot[3] and arvalid, plus input arready.
REQ-011 The block SHALL have R-channel inputs m_mm2s_axi_rdata[DATA_WIDTH], rresp[2], rlast and rvalid, plus output rready.
REQ-012 The block SHALL have stream outputs m_mm2s_axis_tdata[DATA_WIDTH], tvalid and tlast, plus input tready.

Function
REQ-013 The block SHALL accept start_i only in IDLE; in any other state it SHALL ignore start_i.
REQ-014 On accepting a start, the block SHALL latch addr_i with its low log2(DATA_WIDTH/8) bits forced to 0, set the remaining count to len_i+1, clear error_o, and assert busy_o on the next cycle.
REQ-015 The block SHALL implement the states IDLE -> ADDR -> DATA -> (ADDR if beats remain, else DONE) -> IDLE.
REQ-016 In ADDR, the block SHALL hold arvalid high with constant fields until arready is seen, entering ADDR no later than the cycle after start.
REQ-017 The burst length SHALL be min(remaining, MAX_BURST_LEN, beats to the next 4 KB boundary when enabled), and arlen SHALL equal that length minus 1.
REQ-018 The block SHALL drive the fixed AR fields arsize=log2(DATA_WIDTH/8), arburst=2'b01 (INCR), arcache=4'b0011 and arprot=3'b000.
REQ-019 After each AR handshake, the block SHALL advance the address by burst_beats*DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
REQ-020 In DATA, the block SHALL pass data through combinationally: tdata=rdata, tvalid=rvalid, rready=tready, with zero latency; outside DATA both tvalid and rready SHALL be 0.
REQ-021 The block SHALL assert tlast only on the final beat of the whole transfer, never at intermediate burst ends.
REQ-022 The block SHALL support only one outstanding burst, issuing the next AR only after the rlast beat of the current burst is accepted.
REQ-023 The block SHALL set error_o on any accepted beat with rresp!=0, or with rlast mismatching the internal last-of-burst count; the transfer SHALL nonetheless run to completion using the internal count.
REQ-024 In DONE, the block SHALL pulse done_o for exactly 1 cycle, drop busy_o in that same cycle and return to IDLE.
REQ-025 The block SHALL accept a start_i asserted in the DONE cycle on the following IDLE cycle only.
REQ-026 The block SHALL handle len_i=0 as a single-beat transfer, with arlen=0 and tlast on that beat.

Reset
REQ-027 While m_axi_aresetn=0 at a clock edge, the block SHALL enter IDLE and drive arvalid=0, tvalid=0, rready=0, busy_o=0, done_o=0, error_o=0, araddr=0, arlen=0 and tlast=0.
REQ-028 On reset mid-transfer, the block SHALL abandon the transfer immediately without draining outstanding beats; the slave must be reset together with the block.

Configuration
REQ-029 Macro DMA_MM2S_BOUNDARY_4K_EN, when defined, SHALL limit each burst so it does not cross a 4 KB address boundary.
REQ-030 Without DMA_MM2S_BOUNDARY_4K_EN, the block SHALL split bursts by MAX_BURST_LEN and remaining count only.

Verification
REQ-031 The bench SHALL check: addr=0x20, len=15, MAX_BURST_LEN=16 -> one AR with arlen=15; 16 beats out; tlast on beat 16; done_o pulse; error_o=0.
REQ-032 The bench SHALL check: addr=0, len=39, MAX_BURST_LEN=16 -> ARs at 0x000/0x080/0x100 with arlen 15/15/7; tlast only on beat 40.
REQ-033 The bench SHALL check, with DMA_MM2S_BOUNDARY_4K_EN defined: addr=0xFC0, len=15, DATA_WIDTH=64 -> ARs 0xFC0 with arlen=7 and 0x1000 with arlen=7; without the macro -> a single AR with arlen=15.
REQ-034 The bench SHALL check: tready toggled 1010... during a 16-beat read -> rready mirrors tready, no beat lost or duplicated, data order preserved.
REQ-035 The bench SHALL check: slave returns rresp=2'b10 on beat 5 of 16 -> error_o=1 from the next cycle, all 16 beats still delivered, done_o pulses, and error_o clears on the next start.
REQ-036 The bench SHALL check: reset asserted on beat 3 of 16 -> next cycle busy_o=0, arvalid=0, tvalid=0; a fresh start then completes normally.

Source files
------------

// File: rtl/dma_mm2s_burst.sv
`default_nettype none
// ============================================================================
// Module   : dma_mm2s_burst
// Brief    : Memory-mapped to stream read DMA. It splits one transfer into
//            AXI INCR read bursts and passes each R beat straight through to
//            the AXI-Stream output, with one burst outstanding at a time.
// Options  : define DMA_MM2S_BOUNDARY_4K_EN so that no burst crosses a
//            4 KB address boundary.
// Revision : 1.0 - initial release
// ============================================================================
module dma_mm2s_burst #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  // transfer request and status
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  // AXI read address channel
  output logic [ADDR_WIDTH-1:0] m_mm2s_axi_araddr,
  output logic [7:0]            m_mm2s_axi_arlen,
  output logic [2:0]            m_mm2s_axi_arsize,
  output logic [1:0]            m_mm2s_axi_arburst,
  output logic [3:0]            m_mm2s_axi_arcache,
  output logic [2:0]            m_mm2s_axi_arprot,
  output logic                  m_mm2s_axi_arvalid,
  input  logic                  m_mm2s_axi_arready,
  // AXI read data channel
  input  logic [DATA_WIDTH-1:0] m_mm2s_axi_rdata,
  input  logic [1:0]            m_mm2s_axi_rresp,
  input  logic                  m_mm2s_axi_rlast,
  input  logic                  m_mm2s_axi_rvalid,
  output logic                  m_mm2s_axi_rready,
  // AXI-Stream output
  output logic [DATA_WIDTH-1:0] m_mm2s_axis_tdata,
  output logic                  m_mm2s_axis_tvalid,
  output logic                  m_mm2s_axis_tlast,
  input  logic                  m_mm2s_axis_tready
);

  localparam int c_bytes = DATA_WIDTH / 8;
  localparam int c_size  = $clog2(c_bytes);
  // Remaining-beat counter holds len_i+1 and must also hold a full 256-beat burst.
  localparam int c_cnt_w = (LEN_WIDTH + 1 > 9) ? LEN_WIDTH + 1 : 9;
  localparam logic [c_cnt_w-1:0]    c_max_burst  = c_cnt_w'(MAX_BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(c_bytes - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;          // address of the next burst to request
  logic [c_cnt_w-1:0]  remain_q, remain_d;        // beats not yet requested on AR
  logic [8:0]          burst_left_q, burst_left_d; // beats still due in the current burst
  logic [7:0]          arlen_q, arlen_d;
  logic                arvalid_q, arvalid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [ADDR_WIDTH-1:0] w_calc_addr;
  logic [c_cnt_w-1:0]  w_calc_remain;
  logic [8:0]          w_burst;
  logic [8:0]          w_ar_beats;
  logic                w_beat_acc;
  logic                w_burst_end;

  // Size the next burst from either the incoming request (IDLE) or the running state.
  always_comb begin
    w_calc_addr   = addr_q;
    w_calc_remain = remain_q;
    if (state_q == S_IDLE) begin
      w_calc_addr   = addr_i & c_align_mask;
      w_calc_remain = c_cnt_w'(len_i) + c_cnt_w'(1);
    end
    w_burst = (w_calc_remain > c_max_burst) ? c_max_burst[8:0] : w_calc_remain[8:0];
`ifdef DMA_MM2S_BOUNDARY_4K_EN
    begin : g_4k_limit
      logic [12:0] w_to_4k;
      w_to_4k = (13'h1000 - {1'b0, w_calc_addr[11:0]}) >> c_size;
      if (w_to_4k < {4'b0000, w_burst}) begin
        w_burst = w_to_4k[8:0];
      end
    end
`endif
  end

  assign w_ar_beats  = {1'b0, arlen_q} + 9'd1;
  assign w_beat_acc  = (state_q == S_DATA) && m_mm2s_axi_rvalid && m_mm2s_axis_tready;
  assign w_burst_end = (burst_left_q == 9'd1);

  // Next-state and datapath updates for the transfer sequencer.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    burst_left_d = burst_left_q;
    arlen_d      = arlen_q;
    error_d      = error_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_ADDR;
          addr_d   = w_calc_addr;
          remain_d = w_calc_remain;
          arlen_d  = 8'(w_burst - 9'd1);
          error_d  = 1'b0;
        end
      end
      S_ADDR: begin
        if (m_mm2s_axi_arready) begin
          state_d      = S_DATA;
          addr_d       = addr_q + (ADDR_WIDTH'(w_ar_beats) << c_size);
          remain_d     = remain_q - c_cnt_w'(w_ar_beats);
          burst_left_d = w_ar_beats;
        end
      end
      S_DATA: begin
        if (w_beat_acc) begin
          burst_left_d = burst_left_q - 9'd1;
          // Slave errors and misplaced rlast are flagged; the internal count still rules.
          if ((m_mm2s_axi_rresp != 2'b00) || (m_mm2s_axi_rlast != w_burst_end)) begin
            error_d = 1'b1;
          end
          if (w_burst_end) begin
            if (remain_q != '0) begin
              state_d = S_ADDR;
              arlen_d = 8'(w_burst - 9'd1);
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    arvalid_d = (state_d == S_ADDR);
    busy_d    = (state_d == S_ADDR) || (state_d == S_DATA);
    done_d    = (state_d == S_DONE);
  end

  // State and registered outputs, cleared by the synchronous active-low reset.
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      burst_left_q <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      burst_left_q <= burst_left_d;
      arlen_q      <= arlen_d;
      arvalid_q    <= arvalid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign error_o = error_q;

  assign m_mm2s_axi_araddr  = addr_q;
  assign m_mm2s_axi_arlen   = arlen_q;
  assign m_mm2s_axi_arsize  = 3'(c_size);
  assign m_mm2s_axi_arburst = 2'b01;
  assign m_mm2s_axi_arcache = 4'b0011;
  assign m_mm2s_axi_arprot  = 3'b000;
  assign m_mm2s_axi_arvalid = arvalid_q;

  // Zero-latency pass-through; only open while a burst is being received.
  assign m_mm2s_axi_rready  = (state_q == S_DATA) && m_mm2s_axis_tready;
  assign m_mm2s_axis_tdata  = m_mm2s_axi_rdata;
  assign m_mm2s_axis_tvalid = (state_q == S_DATA) && m_mm2s_axi_rvalid;
  assign m_mm2s_axis_tlast  = (state_q == S_DATA) && w_burst_end && (remain_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_dma_mm2s_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_mm2s_burst
// Brief    : Directed self-checking bench for dma_mm2s_burst (default
//            parameters, optional DMA_MM2S_BOUNDARY_4K_EN build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_mm2s_burst;

  logic        clk;
  logic        aresetn;
  logic        start_i;
  logic [31:0] addr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, error_o;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [63:0] tdata;
  logic        tvalid, tlast, tready;

  int total;
  int bad;
  logic [31:0] exp_addr [4];
  logic [7:0]  exp_len  [4];

  dma_mm2s_burst dut (
    .m_axi_aclk         (clk),
    .m_axi_aresetn      (aresetn),
    .start_i            (start_i),
    .addr_i             (addr_i),
    .len_i              (len_i),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .error_o            (error_o),
    .m_mm2s_axi_araddr  (araddr),
    .m_mm2s_axi_arlen   (arlen),
    .m_mm2s_axi_arsize  (arsize),
    .m_mm2s_axi_arburst (arburst),
    .m_mm2s_axi_arcache (arcache),
    .m_mm2s_axi_arprot  (arprot),
    .m_mm2s_axi_arvalid (arvalid),
    .m_mm2s_axi_arready (arready),
    .m_mm2s_axi_rdata   (rdata),
    .m_mm2s_axi_rresp   (rresp),
    .m_mm2s_axi_rlast   (rlast),
    .m_mm2s_axi_rvalid  (rvalid),
    .m_mm2s_axi_rready  (rready),
    .m_mm2s_axis_tdata  (tdata),
    .m_mm2s_axis_tvalid (tvalid),
    .m_mm2s_axis_tlast  (tlast),
    .m_mm2s_axis_tready (tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pattern(input logic [31:0] seed, input int beat);
    return {seed, 32'(beat) ^ 32'h5A5A_0000};
  endfunction

  // One complete transfer: the bench acts as AXI slave and stream sink.
  task automatic xfer(input logic [31:0] a, input logic [15:0] l, input int nb,
                      input logic [31:0] seed, input bit tog, input int err_beat,
                      input int rst_beat, input bit start_in_done);
    int beat;
    int phase;
    int w;
    int total_beats;
    bit acc;
    beat = 0;
    phase = 0;
    total_beats = int'(l) + 1;
    @(negedge clk);
    start_i = 1'b1; addr_i = a; len_i = l;
    @(negedge clk);
    start_i = 1'b0; addr_i = 32'hDEAD_BEEF; len_i = 16'hFFFF;
    chk("busy_start", 64'(busy_o), 64'd1);
    chk("err_clr", 64'(error_o), 64'd0);
    for (int b = 0; b < nb; b++) begin
      w = 0;
      while (!arvalid && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("ar_wait", 64'(arvalid), 64'd1);
      chk("araddr", 64'(araddr), 64'(exp_addr[b]));
      chk("arlen", 64'(arlen), 64'(exp_len[b]));
      if (b == 0) begin
        chk("ar_fixed", 64'({arsize, arburst, arcache, arprot}), 64'({3'd3, 2'b01, 4'b0011, 3'b000}));
      end
      @(negedge clk);
      chk("ar_hold", 64'({arvalid, araddr, arlen}), 64'({1'b1, exp_addr[b], exp_len[b]}));
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("ar_drop", 64'(arvalid), 64'd0);
      for (int k = 0; k <= int'(exp_len[b]); k++) begin
        rvalid = 1'b1;
        rdata  = pattern(seed, beat);
        rlast  = (k == int'(exp_len[b]));
        rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
        acc = 1'b0;
        while (!acc) begin
          tready = tog ? (phase % 2 == 0) : 1'b1;
          phase++;
          #1;
          chk("tvalid", 64'(tvalid), 64'd1);
          chk("tdata", tdata, pattern(seed, beat));
          chk("rready", 64'(rready), 64'(tready));
          chk("tlast", 64'(tlast), 64'(beat == total_beats - 1));
          chk("err_live", 64'(error_o), 64'(err_beat >= 0 && beat > err_beat));
          if (beat == rst_beat) begin
            aresetn = 1'b0;
            @(negedge clk);
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; tready = 1'b1;
            chk("rst_busy", 64'(busy_o), 64'd0);
            chk("rst_arvalid", 64'(arvalid), 64'd0);
            chk("rst_tvalid", 64'(tvalid), 64'd0);
            chk("rst_misc", 64'({rready, done_o, error_o, tlast, araddr, arlen}), 64'd0);
            aresetn = 1'b1;
            return;
          end
          acc = tready;
          @(negedge clk);
        end
        beat++;
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    end
    chk("beats", 64'(beat), 64'(total_beats));
    chk("done_pulse", 64'(done_o), 64'd1);
    chk("busy_done", 64'(busy_o), 64'd0);
    chk("tvalid_done", 64'(tvalid), 64'd0);
    chk("err_end", 64'(error_o), 64'(err_beat >= 0));
    if (start_in_done) begin
      start_i = 1'b1; addr_i = 32'h0000_3000; len_i = 16'd3;
    end
    @(negedge clk);
    start_i = 1'b0;
    chk("done_low", 64'(done_o), 64'd0);
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("idle_arvalid", 64'(arvalid), 64'd0);
    chk("err_sticky", 64'(error_o), 64'(err_beat >= 0));
    if (start_in_done) begin
      @(negedge clk);
      chk("no_restart", 64'({busy_o, arvalid}), 64'd0);
    end
  endtask

  // Watchdog so a stuck run still ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Directed test sequence.
  initial begin
    total = 0;
    bad = 0;
    aresetn = 1'b0;
    start_i = 1'b0; addr_i = '0; len_i = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'({arvalid, tvalid, rready, busy_o, done_o, error_o, tlast}), 64'd0);
    chk("rst_ar", 64'({araddr, arlen}), 64'd0);
    aresetn = 1'b1;
    @(negedge clk);

    // Single full burst at 0x20.
    exp_addr[0] = 32'h20; exp_len[0] = 8'd15;
    xfer(32'h20, 16'd15, 1, 32'h1111_0000, 1'b0, -1, -1, 1'b0);

    // 40 beats split 16/16/8.
    exp_addr[0] = 32'h000; exp_len[0] = 8'd15;
    exp_addr[1] = 32'h080; exp_len[1] = 8'd15;
    exp_addr[2] = 32'h100; exp_len[2] = 8'd7;
    xfer(32'h0, 16'd39, 3, 32'h2222_0000, 1'b0, -1, -1, 1'b0);

    // Transfer that straddles a 4 KB boundary.
`ifdef DMA_MM2S_BOUNDARY_4K_EN
    exp_addr[0] = 32'hFC0;  exp_len[0] = 8'd7;
    exp_addr[1] = 32'h1000; exp_len[1] = 8'd7;
    xfer(32'hFC0, 16'd15, 2, 32'h3333_0000, 1'b0, -1, -1, 1'b0);
`else
    exp_addr[0] = 32'hFC0; exp_len[0] = 8'd15;
    xfer(32'hFC0, 16'd15, 1, 32'h3333_0000, 1'b0, -1, -1, 1'b0);
`endif

    // Back-pressure: tready 1010...
    exp_addr[0] = 32'h200; exp_len[0] = 8'd15;
    xfer(32'h200, 16'd15, 1, 32'h4444_0000, 1'b1, -1, -1, 1'b0);

    // SLVERR on beat 5 of 16; start pulsed in DONE must be ignored.
    exp_addr[0] = 32'h400; exp_len[0] = 8'd15;
    xfer(32'h400, 16'd15, 1, 32'h5555_0000, 1'b0, 4, -1, 1'b1);

    // Single beat from an unaligned address; also clears the sticky error.
    exp_addr[0] = 32'h1000; exp_len[0] = 8'd0;
    xfer(32'h1007, 16'd0, 1, 32'h6666_0000, 1'b0, -1, -1, 1'b0);

    // Reset on beat 3 of 16, then a fresh transfer.
    exp_addr[0] = 32'h40; exp_len[0] = 8'd15;
    xfer(32'h40, 16'd15, 1, 32'h7777_0000, 1'b0, -1, 2, 1'b0);
    @(negedge clk);
    xfer(32'h40, 16'd15, 1, 32'h8888_0000, 1'b0, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
